// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer: sweeps a ROM from address 0 up to a captured end
// address and hands each byte to a consumer over a valid/ready handshake.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   start, abort        - begin a sweep / terminate the current sweep
//   end_address         - last address of the sweep, captured on start
//   rom_data            - ROM data bus
//   address_line        - registered ROM address
//   rom_ce_n, rom_oe_n  - registered active-low chip/output enables
//   data_out/data_valid - captured byte and its valid flag
//   data_ready          - consumer accepts byte when valid and ready
//   busy, done          - sweep in progress / sweep finished
module rom_read_sequencer #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] end_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] address_line,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        CAPTURE,
        HANDOFF,
        DONE
    } state_t;

    // Wait counter reaches this value on the last WAIT cycle.
    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] end_r;
    logic [ADDR_WIDTH-1:0] end_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [3:0]            cnt;
    logic [3:0]            cnt_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;
    logic                  ce_n_n;
    logic                  oe_n_n;
    logic                  busy_n;
    logic                  done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            address_line <= '0;
            end_r        <= '0;
            cnt          <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            rom_ce_n     <= 1'b1;
            rom_oe_n     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            address_line <= addr_n;
            end_r        <= end_n;
            cnt          <= cnt_n;
            data_out     <= data_n;
            data_valid   <= valid_n;
            rom_ce_n     <= ce_n_n;
            rom_oe_n     <= oe_n_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = address_line;
        end_n   = end_r;
        cnt_n   = cnt;
        data_n  = data_out;
        valid_n = data_valid;
        ce_n_n  = rom_ce_n;
        oe_n_n  = rom_oe_n;
        if (abort) begin
            // Abort wins over start and over a handshake on the same edge.
            state_n = IDLE;
            valid_n = 1'b0;
            ce_n_n  = 1'b1;
            oe_n_n  = 1'b1;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr_n  = '0;
                        end_n   = end_address;
                        ce_n_n  = 1'b0;
                        oe_n_n  = 1'b0;
                        state_n = SETUP;
                    end
                end
                SETUP: begin
                    cnt_n   = '0;
                    state_n = WAIT;
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        state_n = CAPTURE;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    data_n  = rom_data;
                    valid_n = 1'b1;
                    state_n = HANDOFF;
                end
                HANDOFF: begin
                    if (data_ready) begin
                        valid_n = 1'b0;
                        // Compare before incrementing so the address never wraps.
                        if (address_line == end_r) begin
                            ce_n_n  = 1'b1;
                            oe_n_n  = 1'b1;
                            state_n = DONE;
                        end else begin
                            addr_n  = address_line + 1'b1;
                            state_n = SETUP;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
        busy_n = (state_n != IDLE) && (state_n != DONE);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// tb_rom_read_sequencer: directed scoreboard bench for rom_read_sequencer.
// Expected bytes are queued at start and popped on each handshake.
module tb_rom_read_sequencer;

    localparam int AW = 9;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] end_address = '0;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] address_line;
    logic          rom_ce_n;
    logic          rom_oe_n;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic          busy;
    logic          done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   last_hs = -1;
    bit   check_period = 1'b0;
    bit   hold_armed = 1'b0;
    logic [DW-1:0] hold_val;
    exp_t exp_q[$];

    rom_read_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .end_address  (end_address),
        .rom_data     (rom_data),
        .address_line (address_line),
        .rom_ce_n     (rom_ce_n),
        .rom_oe_n     (rom_oe_n),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .done         (done)
    );

    assign rom_data = address_line[7:0] ^ 8'h5A;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: a handshake completes on the next rising edge
    // unless reset or abort override it.
    always @(negedge clk) begin
        exp_t e;
        if (hold_armed && data_valid && !reset && !abort)
            chk("hold_stable", 32'(data_out), 32'(hold_val));
        hold_armed = 1'b0;
        if (!reset && !abort && data_valid) begin
            if (data_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(address_line), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_addr", 32'(address_line), 32'(e.addr));
                    chk("byte_data", 32'(data_out), 32'(e.data));
                end
                if (check_period && last_hs >= 0)
                    chk("period", 32'(cyc - last_hs), 32'd7);
                last_hs = cyc;
                hs_cnt++;
            end else begin
                hold_val   = data_out;
                hold_armed = 1'b1;
            end
        end
    end

    task automatic start_sweep(input logic [AW-1:0] e);
        exp_t x;
        start       = 1'b1;
        end_address = e;
        for (int a = 0; a <= int'(e); a++) begin
            x.addr = AW'(a);
            x.data = DW'(a) ^ 8'h5A;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (!done && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic chk_reset_vals(string p);
        chk({p, "_addr"}, 32'(address_line), 32'd0);
        chk({p, "_data"}, 32'(data_out), 32'd0);
        chk({p, "_valid"}, 32'(data_valid), 32'd0);
        chk({p, "_ce"}, 32'(rom_ce_n), 32'd1);
        chk({p, "_oe"}, 32'(rom_oe_n), 32'd1);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single byte, data_valid exactly at edge 6.
        base = hs_cnt;
        start_sweep(0);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_ce", 32'(rom_ce_n), 32'd0);
        chk("single_oe", 32'(rom_oe_n), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("single_early_valid", 32'(data_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("single_valid_e6", 32'(data_valid), 32'd1);
        chk("single_data", 32'(data_out), 32'h5A);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("single_done", 32'(done), 32'd1);
        chk("single_ce_off", 32'(rom_ce_n), 32'd1);
        chk("single_oe_off", 32'(rom_oe_n), 32'd1);
        chk("single_valid_off", 32'(data_valid), 32'd0);
        chk("single_count", 32'(hs_cnt - base), 32'd1);

        // Full sweep, data_ready tied high.
        base         = hs_cnt;
        last_hs      = -1;
        check_period = 1'b1;
        start_sweep(9'd511);
        n = 0;
        while (!done && n < 4000) begin
            chk("sweep_ce_low", 32'(rom_ce_n | rom_oe_n), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_done", 32'(done), 32'd1);
        check_period = 1'b0;
        chk("sweep_count", 32'(hs_cnt - base), 32'd512);
        chk("sweep_q_empty", 32'(exp_q.size()), 32'd0);
        chk("sweep_addr", 32'(address_line), 32'd511);

        // Backpressure with ~30% ready.
        base       = hs_cnt;
        data_ready = 1'b0;
        start_sweep(3);
        n = 0;
        while (!done && n < 3000) begin
            data_ready = ($urandom_range(0, 9) < 3);
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_count", 32'(hs_cnt - base), 32'd4);
        chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // Abort during WAIT of address 5.
        data_ready = 1'b1;
        start_sweep(10);
        n = 0;
        while (address_line != 9'd5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reach5", 32'(address_line), 32'd5);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid", 32'(data_valid), 32'd0);
        chk("abort_ce", 32'(rom_ce_n), 32'd1);
        chk("abort_oe", 32'(rom_oe_n), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(address_line), 32'd5);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_stays_idle", 32'(busy), 32'd0);
        exp_q.delete();

        // Abort and start on the same edge: no sweep.
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_ce", 32'(rom_ce_n), 32'd1);

        // Restart after abort begins at 0.
        base = hs_cnt;
        start_sweep(1);
        chk("restart_addr", 32'(address_line), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_done(100, "restart_done");
        chk("restart_count", 32'(hs_cnt - base), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", 32'(done), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_clears_done", 32'(done), 32'd0);

        // Start pulsed while busy, end_address scrambled while busy.
        base = hs_cnt;
        start_sweep(7);
        n = 0;
        while (!done && n < 500) begin
            start       = (hs_cnt - base < 8);
            end_address = AW'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_count", 32'(hs_cnt - base), 32'd8);
        chk("ign_q_empty", 32'(exp_q.size()), 32'd0);
        chk("ign_addr", 32'(address_line), 32'd7);
        @(posedge clk);
        #1;
        chk("ign_no_restart", 32'(done), 32'd1);

        // Reset in HANDOFF with data_ready high on the same edge.
        data_ready = 1'b0;
        start_sweep(3);
        n = 0;
        while (!data_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reach_handoff", 32'(data_valid), 32'd1);
        base       = hs_cnt;
        data_ready = 1'b1;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        data_ready = 1'b0;
        exp_q.delete();
        chk("rst_no_byte", 32'(hs_cnt - base), 32'd0);
        chk_reset_vals("midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_read_sequencer.md
ROM_READ_SEQUENCER -- requirements
Module: rom_read_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, ROM data width.
REQ-003 SHALL have parameter ACCESS_CYCLES, default 4, range 1..15, ROM access wait in clk cycles.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a read sweep; sampled only in IDLE or DONE.
REQ-007 abort  input  1  terminate sweep; highest priority after reset.
REQ-008 end_address  input  ADDR_WIDTH  last address of sweep; captured on accepted start.
REQ-009 rom_data  input  DATA_WIDTH  ROM data bus.
REQ-010 address_line  output  ADDR_WIDTH  registered ROM address; also drives the address display.
REQ-011 rom_ce_n  output  1  registered ROM chip enable, active-low.
REQ-012 rom_oe_n  output  1  registered ROM output enable, active-low.
REQ-013 data_out  output  DATA_WIDTH  captured byte, stable while data_valid=1.
REQ-014 data_valid  output  1  byte available to consumer.
REQ-015 data_ready  input  1  consumer accepts byte when data_valid=1 and data_ready=1 on same edge.
REQ-016 busy  output  1  high in every state except IDLE and DONE.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, SETUP, WAIT, CAPTURE, HANDOFF, DONE; all outputs registered.
REQ-019 IDLE/DONE with start=1 SHALL: address_line<=0, end register<=end_address, rom_ce_n<=0, rom_oe_n<=0, go SETUP.
REQ-020 SETUP SHALL last exactly 1 cycle, clear wait counter, go WAIT.
REQ-021 WAIT SHALL last exactly ACCESS_CYCLES cycles, then go CAPTURE.
REQ-022 CAPTURE SHALL register data_out<=rom_data, set data_valid<=1, go HANDOFF; data_valid high ACCESS_CYCLES+2 edges after the start-sampling edge.
REQ-023 HANDOFF SHALL hold data_out and data_valid until handshake edge; no timeout.
REQ-024 On handshake with address_line != end register: data_valid<=0, address_line<=address_line+1, go SETUP.
REQ-025 On handshake with address_line == end register: data_valid<=0, rom_ce_n<=1, rom_oe_n<=1, go DONE; address_line held.
REQ-026 With data_ready tied high, byte period SHALL be ACCESS_CYCLES+3 cycles (7 at default).
REQ-027 rom_ce_n/rom_oe_n SHALL stay low continuously from sweep start to last handshake (no deassert between bytes).
REQ-028 address_line SHALL never exceed end register and SHALL never wrap; end_address=2^ADDR_WIDTH-1 reads all locations without overflow.
REQ-029 end_address=0 SHALL read exactly one byte.
REQ-030 start while busy=1 SHALL be ignored; end_address changes while busy ignored.
REQ-031 abort=1 in any busy state SHALL next edge: go IDLE, data_valid<=0, rom_ce_n<=1, rom_oe_n<=1, address_line held; abort overrides simultaneous handshake.
REQ-032 abort in IDLE/DONE SHALL go IDLE (clears done); abort with start same edge: abort wins, no sweep.
REQ-033 DONE SHALL hold done=1 until start (restart) or abort/reset.

Reset
REQ-034 reset=1 SHALL on next edge force state IDLE from any state, overriding start/abort.
REQ-035 Reset values: address_line=0, data_out=0, data_valid=0, rom_ce_n=1, rom_oe_n=1, busy=0, done=0, wait counter=0, end register=0.
REQ-036 Reset mid-sweep SHALL discard pending byte with no handshake completing on that edge.

Verification
REQ-037 Full sweep: ROM model data=addr[7:0]^8'h5A, end_address=511, data_ready=1 -> 512 bytes in address order, matching model, period 7 cycles, done=1 after last, address_line=511.
REQ-038 Backpressure: end_address=3, data_ready random 30% -> 4 bytes, data_out stable while valid&!ready, no loss/duplication.
REQ-039 Single byte: end_address=0, start -> data_valid at edge 6, one byte, DONE, rom_ce_n=rom_oe_n=1.
REQ-040 Abort: abort during WAIT of address 5 -> IDLE next edge, data_valid=0, CE/OE high, address_line=5; later start restarts at 0.
REQ-041 Ignored start: start pulses every cycle during sweep of end_address=7 -> exactly 8 bytes, addresses 0..7.
REQ-042 Reset mid-HANDOFF with data_ready=1 same edge -> no byte counted, all outputs equal REQ-035 values.
